ime_sad_acc: RTL and testbench
==============================

Name: ime_sad_acc

Overview:
- Pipelined, parametrised sum-of-absolute-differences engine for integer motion estimation.
- Each valid cycle takes one row of PIX_NUM current pixels and PIX_NUM reference pixels.
- Per row: forms per-pixel absolute differences, reduces them through an adder tree, and accumulates ROW_NUM rows into one block SAD.
- Provides a sticky early-termination flag against a programmable threshold. Sits between the IME reference-window fetch and the IME cost/compare logic.

Parameters:
- BIT_DEPTH, 8: pixel width in bits.
- PIX_NUM, 16: pixels per row; power of two, 2..64.
- ROW_NUM, 16: rows per block; power of two, 1..64.
- SAD_W, BIT_DEPTH+log2(PIX_NUM*ROW_NUM) (16 at defaults): width of the block SAD, threshold and partial sum.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- clear_i, in, 1: synchronous abort of the current block.
- valid_i, in, 1: cur_i/ref_i carry one valid row this cycle.
- cur_i, in, PIX_NUM*BIT_DEPTH: current pixels; pixel k is at bits [k*BIT_DEPTH +: BIT_DEPTH].
- ref_i, in, PIX_NUM*BIT_DEPTH: reference pixels, same packing as cur_i.
- thr_i, in, SAD_W: early-termination threshold; sampled every cycle.
- sad_o, out, SAD_W: block SAD; holds its value until the next block completes.
- sad_valid_o, out, 1: one-cycle pulse when sad_o updates.
- early_term_o, out, 1: partial SAD of the current block is greater than thr_i.
- busy_o, out, 1: a block is partially received or in flight.

Behaviour:
- Reset (rst=1): every output is 0; the row counter, all pipeline valid/first/last flags and the accumulator are cleared. A row presented in the same cycle as rst is dropped.
- Stage 1 (registered), per pixel k: diff = {0,cur} - {0,ref}, computed at BIT_DEPTH+1 bits. If diff is negative, abs = two's complement of its low BIT_DEPTH bits; otherwise abs = the low bits. Result is BIT_DEPTH bits.
- Stage 2 (registered): binary adder tree over the PIX_NUM abs values. Row sum width is BIT_DEPTH+log2(PIX_NUM), so no overflow is possible.
- Stage 3 (registered accumulator):
  - First row of a block: acc <= row_sum.
  - Other rows: acc <= acc + row_sum.
  - Width is SAD_W; overflow is impossible by construction.
- Row counter (input side):
  - Increments on each accepted valid_i.
  - Count 0 tags the row "first"; count ROW_NUM-1 tags it "last", then the counter wraps to 0.
  - The first/last tags travel with the row's valid flag through all stages.
- Output timing: if the last row is accepted at cycle t, then at t+3 sad_o = final accumulator value and sad_valid_o = 1 for exactly one cycle.
- Throughput: one row per cycle, back-to-back blocks with no gap. The first row of block n+1 may be accepted at t+1.
- Pipeline control: no backpressure; the consumer must accept the sad_valid_o pulse.
- FSM, two states on the input side:
  - IDLE: counter = 0.
  - ACC: 0 < counter ≤ ROW_NUM-1.
  - IDLE→ACC on valid_i when ROW_NUM > 1.
  - ACC→IDLE on the last row or on clear_i.
  - ROW_NUM = 1: every row is both first and last, and the FSM stays in IDLE.
- busy_o = (state == ACC) OR any stage valid flag is set.
- early_term_o:
  - Goes to 1 in the cycle after the accumulator update that leaves acc > thr_i (strictly greater).
  - Sticky until the next first-row load into the accumulator.
  - Cleared by clear_i/rst.
  - An early-terminated block still completes and pulses sad_valid_o unless clear_i is asserted.
- clear_i:
  - Zeroes the counter and all stage valid flags and clears early_term_o, next cycle.
  - Does not alter sad_o.
  - A row presented with clear_i is dropped.
  - A completing block whose last row is in stage 2/3 is killed, so no sad_valid_o pulse.
- Zero-length gaps: valid_i may drop mid-block; the counter holds and the pipeline bubbles.

Decomposition:
- Shared package / enc_defines: BIT_DEPTH, the log2 helper, and the IDLE/ACC state encodings.
- One natural sub-module: ime_sad_tree. It is the parametrised per-row abs-diff plus adder tree (stages 1–2), with PIX_NUM and BIT_DEPTH parameters.
- Counter, FSM, accumulator and threshold logic stay in ime_sad_acc.

Test Plan:
- Defaults; 16 rows with all cur = 200 and all ref = 50 → sad_valid_o pulses exactly 3 cycles after the 16th valid_i; sad_o = 38400 (16×16×150).
- Rows with cur = 0 and ref = 255, then a second block with cur = 255 and ref = 0, back-to-back → two pulses 16 cycles apart; both sad_o = 65280; no bubble.
- thr_i = 1000, rows of per-pixel diff 10 (row sum 160) → early_term_o rises after the 7th row's update (acc = 1120); stays 1; clears on the next block's first load.
- clear_i asserted while the 10th row is accepted, then 16 fresh rows of diff 1 → no pulse for the aborted block; next sad_o = 256; early_term_o = 0.
- rst pulsed for one cycle mid-block and while a last row is in stage 2 → all outputs 0, no sad_valid_o; a fresh block afterwards completes normally.
- PIX_NUM = 4, ROW_NUM = 1, BIT_DEPTH = 10; cur = {1023, 0, 5, 7}, ref = {0, 1023, 7, 5} → sad_valid_o every cycle; sad_o = 2050; busy_o high only while in flight.

Source files
------------

// File: rtl/ime_sad_acc_pkg.sv
// Shared definitions for the IME SAD engine.
//   DEF_BIT_DEPTH : default pixel width
//   state_e       : input-side row FSM states
//   log2c         : ceiling log2, for deriving widths from parameters
package ime_sad_acc_pkg;

  localparam int unsigned DEF_BIT_DEPTH = 8;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StAcc  = 1'b1
  } state_e;

  function automatic int unsigned log2c(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ime_sad_tree.sv
// Per-row absolute-difference and adder-tree front end (two register stages).
//   clk, rst           : clock, synchronous active-high reset
//   flush_i            : drops everything in flight (valid/first/last flags)
//   valid_i/first_i/last_i : row strobe and block position tags
//   cur_i, ref_i       : PIX_NUM packed pixels, pixel k at [k*BIT_DEPTH +: BIT_DEPTH]
//   valid_o/first_o/last_o : tags aligned with row_sum_o
//   row_sum_o          : sum of |cur - ref| over the row
//   busy_o             : a row is held in either stage
module ime_sad_tree
  import ime_sad_acc_pkg::*;
#(
  parameter int unsigned BIT_DEPTH = DEF_BIT_DEPTH,
  parameter int unsigned PIX_NUM   = 16,
  parameter int unsigned ROW_W     = BIT_DEPTH + log2c(PIX_NUM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         valid_i,
  input  logic                         first_i,
  input  logic                         last_i,
  input  logic [PIX_NUM*BIT_DEPTH-1:0] cur_i,
  input  logic [PIX_NUM*BIT_DEPTH-1:0] ref_i,
  output logic                         valid_o,
  output logic                         first_o,
  output logic                         last_o,
  output logic                         busy_o,
  output logic [ROW_W-1:0]             row_sum_o
);

  // Difference formed one bit wider so the sign is never lost.
  function automatic logic [BIT_DEPTH-1:0] abs_diff(input logic [BIT_DEPTH-1:0] a,
                                                    input logic [BIT_DEPTH-1:0] b);
    logic [BIT_DEPTH:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return diff[BIT_DEPTH] ? -diff[BIT_DEPTH-1:0] : diff[BIT_DEPTH-1:0];
  endfunction

  // Pairwise reduction, halving the live width each level.
  function automatic logic [ROW_W-1:0] tree_sum(input logic [BIT_DEPTH-1:0] v [PIX_NUM]);
    logic [ROW_W-1:0] node [PIX_NUM];
    for (int k = 0; k < int'(PIX_NUM); k++) node[k] = ROW_W'(v[k]);
    for (int w = int'(PIX_NUM) / 2; w > 0; w = w / 2) begin
      for (int k = 0; k < w; k++) node[k] = node[2*k] + node[2*k+1];
    end
    return node[0];
  endfunction

  logic [BIT_DEPTH-1:0] abs_d [PIX_NUM];
  logic [BIT_DEPTH-1:0] abs_q [PIX_NUM];
  logic [ROW_W-1:0]     row_sum_d, row_sum_q;
  logic                 s1_valid_q, s1_first_q, s1_last_q;
  logic                 s2_valid_q, s2_first_q, s2_last_q;

  always_comb begin
    for (int k = 0; k < int'(PIX_NUM); k++) begin
      abs_d[k] = abs_diff(cur_i[k*BIT_DEPTH +: BIT_DEPTH], ref_i[k*BIT_DEPTH +: BIT_DEPTH]);
    end
  end

  always_comb begin
    row_sum_d = tree_sum(abs_q);
  end

  // Datapath needs no reset: the flags below qualify it.
  always_ff @(posedge clk) begin
    abs_q     <= abs_d;
    row_sum_q <= row_sum_d;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= valid_i;
      s1_first_q <= valid_i & first_i;
      s1_last_q  <= valid_i & last_i;
      s2_valid_q <= s1_valid_q;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
    end
  end

  assign valid_o   = s2_valid_q;
  assign first_o   = s2_first_q;
  assign last_o    = s2_last_q;
  assign busy_o    = s1_valid_q | s2_valid_q;
  assign row_sum_o = row_sum_q;

endmodule

// File: rtl/ime_sad_acc.sv
// Pipelined block SAD engine for integer motion estimation.
// One row per cycle in; ROW_NUM rows are accumulated into a block SAD.
//   clk, rst      : clock, synchronous active-high reset
//   clear_i       : abort the current block (in-flight rows are killed)
//   valid_i       : cur_i/ref_i carry a row
//   cur_i, ref_i  : packed pixels, pixel k at [k*BIT_DEPTH +: BIT_DEPTH]
//   thr_i         : early-termination threshold
//   sad_o         : last completed block SAD (held)
//   sad_valid_o   : one-cycle pulse when sad_o updates
//   early_term_o  : sticky, partial SAD of current block exceeded thr_i
//   busy_o        : block partially received or rows in flight
module ime_sad_acc
  import ime_sad_acc_pkg::*;
#(
  parameter int unsigned BIT_DEPTH = DEF_BIT_DEPTH,
  parameter int unsigned PIX_NUM   = 16,
  parameter int unsigned ROW_NUM   = 16,
  parameter int unsigned SAD_W     = BIT_DEPTH + log2c(PIX_NUM * ROW_NUM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_i,
  input  logic                         valid_i,
  input  logic [PIX_NUM*BIT_DEPTH-1:0] cur_i,
  input  logic [PIX_NUM*BIT_DEPTH-1:0] ref_i,
  input  logic [SAD_W-1:0]             thr_i,
  output logic [SAD_W-1:0]             sad_o,
  output logic                         sad_valid_o,
  output logic                         early_term_o,
  output logic                         busy_o
);

  localparam int unsigned ROW_W = BIT_DEPTH + log2c(PIX_NUM);
  localparam int unsigned CNT_W = (ROW_NUM > 1) ? log2c(ROW_NUM) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             row_first, row_last;

  logic             t_valid, t_first, t_last, t_busy;
  logic [ROW_W-1:0] t_row_sum;

  logic [SAD_W-1:0] acc_q, acc_d;
  logic [SAD_W-1:0] sad_q, sad_d;
  logic             sad_valid_q, sad_valid_d;
  logic             early_q, early_d;
  logic             upd_q, upd_d;   // acc_q was written at the previous edge

  assign row_first = (cnt_q == '0);
  assign row_last  = (cnt_q == CNT_W'(ROW_NUM - 1));

  // Input-side row counter and FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (valid_i) begin
      if (row_last) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        state_d = StAcc;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  ime_sad_tree #(
    .BIT_DEPTH (BIT_DEPTH),
    .PIX_NUM   (PIX_NUM),
    .ROW_W     (ROW_W)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (clear_i),
    .valid_i   (valid_i),
    .first_i   (row_first),
    .last_i    (row_last),
    .cur_i     (cur_i),
    .ref_i     (ref_i),
    .valid_o   (t_valid),
    .first_o   (t_first),
    .last_o    (t_last),
    .busy_o    (t_busy),
    .row_sum_o (t_row_sum)
  );

  // Accumulator, result register and early-termination flag.
  always_comb begin
    acc_d       = acc_q;
    sad_d       = sad_q;
    sad_valid_d = 1'b0;
    upd_d       = 1'b0;
    // Compare the registered acc so the flag lands one cycle after the update.
    early_d     = early_q | (upd_q & (acc_q > thr_i));
    if (t_valid) begin
      acc_d = t_first ? SAD_W'(t_row_sum) : acc_q + SAD_W'(t_row_sum);
      upd_d = 1'b1;
      if (t_first) early_d = 1'b0;
      if (t_last) begin
        sad_d       = acc_d;
        sad_valid_d = 1'b1;
      end
    end
    // Abort kills a completing block but leaves the previous result intact.
    if (clear_i) begin
      acc_d       = acc_q;
      sad_d       = sad_q;
      sad_valid_d = 1'b0;
      upd_d       = 1'b0;
      early_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      sad_q       <= '0;
      sad_valid_q <= 1'b0;
      upd_q       <= 1'b0;
      early_q     <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      sad_q       <= sad_d;
      sad_valid_q <= sad_valid_d;
      upd_q       <= upd_d;
      early_q     <= early_d;
    end
  end

  assign sad_o        = sad_q;
  assign sad_valid_o  = sad_valid_q;
  assign early_term_o = early_q;
  assign busy_o       = (state_q == StAcc) | t_busy;

endmodule

// File: tb/tb_ime_sad_acc.sv
module tb_ime_sad_acc;

  localparam int unsigned BD = 8;
  localparam int unsigned PN = 16;
  localparam int unsigned RN = 16;
  localparam int unsigned SW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (defaults)
  logic            rst, clear, valid;
  logic [PN*BD-1:0] cur, ref_px;
  logic [SW-1:0]   thr;
  logic [SW-1:0]   sad;
  logic            sad_valid, early, busy;

  ime_sad_acc #(
    .BIT_DEPTH (BD),
    .PIX_NUM   (PN),
    .ROW_NUM   (RN),
    .SAD_W     (SW)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clear),
    .valid_i      (valid),
    .cur_i        (cur),
    .ref_i        (ref_px),
    .thr_i        (thr),
    .sad_o        (sad),
    .sad_valid_o  (sad_valid),
    .early_term_o (early),
    .busy_o       (busy)
  );

  // Small instance: PIX_NUM=4, ROW_NUM=1, BIT_DEPTH=10
  logic        s_clear, s_valid;
  logic [39:0] s_cur, s_ref;
  logic [11:0] s_thr, s_sad;
  logic        s_sad_valid, s_early, s_busy;

  ime_sad_acc #(
    .BIT_DEPTH (10),
    .PIX_NUM   (4),
    .ROW_NUM   (1),
    .SAD_W     (12)
  ) u_small (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (s_clear),
    .valid_i      (s_valid),
    .cur_i        (s_cur),
    .ref_i        (s_ref),
    .thr_i        (s_thr),
    .sad_o        (s_sad),
    .sad_valid_o  (s_sad_valid),
    .early_term_o (s_early),
    .busy_o       (s_busy)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned edge_n = 0;

  // Behavioural model: rows waiting for their accumulator slot.
  typedef struct {
    int unsigned sum;
    bit          first;
    bit          last;
    int unsigned at;
  } row_t;

  row_t        pipe[$];
  int unsigned m_cnt = 0, m_acc = 0, m_sad = 0;
  bit          m_sad_valid = 0, m_early = 0, m_upd = 0;
  int unsigned pulses[$];
  int unsigned pulse_sad[$];

  function automatic int unsigned row_sad(input logic [PN*BD-1:0] c, input logic [PN*BD-1:0] r);
    int unsigned s, a, b;
    s = 0;
    for (int k = 0; k < int'(PN); k++) begin
      a = c[k*BD +: BD];
      b = r[k*BD +: BD];
      s += (a > b) ? a - b : b - a;
    end
    return s;
  endfunction

  function automatic int unsigned small_sad(input logic [39:0] c, input logic [39:0] r);
    int unsigned s, a, b;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      a = c[k*10 +: 10];
      b = r[k*10 +: 10];
      s += (a > b) ? a - b : b - a;
    end
    return s;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (edge %0d): got %0d, want %0d", name, edge_n, act, exp);
    end
  endfunction

  // Apply the spec rules for the coming clock edge using the current inputs.
  task automatic model_edge();
    bit          upd_prev, first_load;
    int unsigned acc_prev;
    row_t        r;
    upd_prev   = m_upd;
    acc_prev   = m_acc;
    first_load = 0;
    edge_n++;
    if (rst || clear) begin
      pipe.delete();
      m_cnt       = 0;
      m_sad_valid = 0;
      m_upd       = 0;
      m_early     = 0;
      if (rst) begin
        m_acc = 0;
        m_sad = 0;
      end
      return;
    end
    m_sad_valid = 0;
    m_upd       = 0;
    // A row reaches the accumulator two edges after it was accepted.
    if (pipe.size() > 0 && pipe[0].at + 2 == edge_n) begin
      r          = pipe.pop_front();
      m_acc      = r.first ? r.sum : m_acc + r.sum;
      m_upd      = 1;
      first_load = r.first;
      if (r.last) begin
        m_sad       = m_acc;
        m_sad_valid = 1;
      end
    end
    m_early = first_load ? 1'b0 : (m_early | (upd_prev && acc_prev > thr));
    if (valid) begin
      r.sum   = row_sad(cur, ref_px);
      r.first = (m_cnt == 0);
      r.last  = (m_cnt == RN - 1);
      r.at    = edge_n;
      pipe.push_back(r);
      m_cnt = (m_cnt + 1) % RN;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("sad_o", sad, m_sad);
    chk("sad_valid_o", sad_valid, m_sad_valid);
    chk("early_term_o", early, m_early);
    chk("busy_o", busy, (m_cnt != 0 || pipe.size() != 0));
    if (sad_valid) begin
      pulses.push_back(edge_n);
      pulse_sad.push_back(sad);
    end
  endtask

  task automatic set_row(input int unsigned c, input int unsigned r);
    for (int k = 0; k < int'(PN); k++) begin
      cur[k*BD +: BD]    = BD'(c);
      ref_px[k*BD +: BD] = BD'(r);
    end
  endtask

  logic [39:0] sc [6];
  logic [39:0] sr [6];
  int unsigned sexp [6];

  initial begin
    rst = 1; clear = 0; valid = 0; cur = '0; ref_px = '0; thr = '1;
    s_clear = 0; s_valid = 0; s_cur = '0; s_ref = '0; s_thr = 12'hfff;

    // Reset
    step();
    step();
    chk("reset sad_o", sad, 0);
    chk("reset sad_valid_o", sad_valid, 0);
    chk("reset early_term_o", early, 0);
    chk("reset busy_o", busy, 0);
    rst = 0;

    // Uniform block, latency of the pulse
    set_row(200, 50);
    valid = 1;
    repeat (16) step();
    valid = 0;
    step();
    chk("t1 busy after last row", busy, 1);
    step();
    chk("t1 pulse at +3", sad_valid, 1);
    chk("t1 sad_o", sad, 38400);
    chk("t1 model sad", m_sad, 38400);
    step();
    chk("t1 pulse width", sad_valid, 0);
    chk("t1 sad_o held", sad, 38400);

    // Back-to-back blocks, extreme pixels
    pulses.delete();
    pulse_sad.delete();
    valid = 1;
    set_row(0, 255);
    repeat (16) step();
    set_row(255, 0);
    repeat (16) step();
    valid = 0;
    repeat (3) step();
    chk("t2 pulse count", pulses.size(), 2);
    if (pulses.size() == 2) begin
      chk("t2 pulse spacing", pulses[1] - pulses[0], 16);
      chk("t2 sad block a", pulse_sad[0], 65280);
      chk("t2 sad block b", pulse_sad[1], 65280);
    end

    // Early termination, sticky until the next first-row load
    thr = 16'd1000;
    set_row(30, 20);
    valid = 1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 9) chk("t3 early before", early, 0);
      if (i == 10) chk("t3 early rises", early, 1);
    end
    set_row(5, 5);
    for (int j = 1; j <= 16; j++) begin
      step();
      if (j == 2) chk("t3 early sticky", early, 1);
      if (j == 3) chk("t3 early cleared", early, 0);
    end
    valid = 0;
    repeat (3) step();
    chk("t3 zero block sad", sad, 0);
    chk("t3 early stays low", early, 0);

    // Abort with clear_i on the 10th row
    pulses.delete();
    set_row(20, 10);
    valid = 1;
    repeat (9) step();
    clear = 1;
    step();
    clear = 0;
    chk("t4 busy after clear", busy, 0);
    chk("t4 early after clear", early, 0);
    set_row(7, 8);
    repeat (16) step();
    valid = 0;
    repeat (3) step();
    chk("t4 pulse count", pulses.size(), 1);
    chk("t4 sad_o", sad, 256);
    chk("t4 early", early, 0);

    // Reset mid-block and with a last row in stage 2
    pulses.delete();
    set_row(100, 0);
    valid = 1;
    repeat (5) step();
    rst = 1;
    step();
    rst = 0;
    chk("t5 sad after rst", sad, 0);
    chk("t5 busy after rst", busy, 0);
    repeat (16) step();
    valid = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    step();
    chk("t5 killed pulses", pulses.size(), 0);
    chk("t5 sad after second rst", sad, 0);
    chk("t5 busy after second rst", busy, 0);
    set_row(9, 4);
    valid = 1;
    repeat (16) step();
    valid = 0;
    repeat (3) step();
    chk("t5 fresh block sad", sad, 1280);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      if (n % 50 == 0) thr = SW'($urandom_range(0, 40000));
      valid = ($urandom_range(0, 3) != 0);
      for (int w = 0; w < int'(PN * BD / 32); w++) begin
        cur[w*32 +: 32]    = $urandom();
        ref_px[w*32 +: 32] = $urandom();
      end
      clear = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 149) == 0);
      step();
    end
    valid = 0; clear = 0; rst = 0;
    repeat (4) step();

    // PIX_NUM=4 / ROW_NUM=1 / BIT_DEPTH=10 instance
    sc[0] = {10'd1023, 10'd0, 10'd5, 10'd7};
    sr[0] = {10'd0, 10'd1023, 10'd7, 10'd5};
    for (int i = 1; i < 6; i++) begin
      sc[i] = {8'($urandom()), $urandom()};
      sr[i] = {8'($urandom()), $urandom()};
    end
    for (int i = 0; i < 6; i++) sexp[i] = small_sad(sc[i], sr[i]);
    chk("small model literal", sexp[0], 2050);
    for (int i = 0; i < 9; i++) begin
      s_valid = (i < 6);
      if (i < 6) begin
        s_cur = sc[i];
        s_ref = sr[i];
      end
      step();
      chk("small sad_valid_o", s_sad_valid, (i >= 2 && i <= 7));
      if (i >= 2 && i <= 7) chk("small sad_o", s_sad, sexp[i-2]);
      if (i == 2) chk("small sad_o literal", s_sad, 2050);
      chk("small busy_o", s_busy, (i <= 6));
      chk("small early_term_o", s_early, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
